// File: rtl/fifo_ctrl.sv
// Push/pop sequencing controller for the dual-port ram_vector FIFO: pointers, occupancy FSM, flags.
// Optional sticky overflow/underflow flags are built when FIFO_CTRL_ERR_EN is defined.
module fifo_ctrl #(
  // Default mirrors fifo_pkg::VECTOR_SIZE; kept local so this file stands alone.
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
`ifdef FIFO_CTRL_ERR_EN
  input  logic          clr_err,
  output logic          overflow,
  output logic          underflow,
`endif
  output logic          wr_en,
  output logic          rd_en,
  output logic [AW-1:0] count_push,
  output logic [AW-1:0] count_pop,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   usedw,
  output logic          pop_valid
);

  typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   usedw_reg, usedw_next;
  logic          pop_valid_reg;
  logic          push_ok, pop_ok;

  assign full       = (state_reg == S_FULL);
  assign empty      = (state_reg == S_EMPTY);
  assign wr_en      = push_ok;
  assign rd_en      = pop_ok;
  assign count_push = wr_ptr_reg;
  assign count_pop  = rd_ptr_reg;
  assign usedw      = usedw_reg;
  assign pop_valid  = pop_valid_reg;

  always_comb begin
    // Requests are masked during reset so no RAM enable escapes.
    push_ok     = push & ~rst & (~full | pop);
    pop_ok      = pop & ~rst & ~empty;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    usedw_next  = usedw_reg;
    state_next  = state_reg;

    if (push_ok) wr_ptr_next = wr_ptr_reg + AW'(1);
    if (pop_ok)  rd_ptr_next = rd_ptr_reg + AW'(1);

    case ({push_ok, pop_ok})
      2'b10:   usedw_next = usedw_reg + (AW+1)'(1);
      2'b01:   usedw_next = usedw_reg - (AW+1)'(1);
      default: usedw_next = usedw_reg;
    endcase

    case (state_reg)
      S_EMPTY: begin
        if (push_ok) state_next = S_PARTIAL;
      end
      S_PARTIAL: begin
        if (push_ok && !pop_ok && usedw_reg == (AW+1)'(DEPTH-1))
          state_next = S_FULL;
        else if (pop_ok && !push_ok && usedw_reg == (AW+1)'(1))
          state_next = S_EMPTY;
      end
      S_FULL: begin
        if (pop_ok && !push_ok) state_next = S_PARTIAL;
      end
      default: state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_EMPTY;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      usedw_reg     <= '0;
      pop_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      usedw_reg     <= usedw_next;
      pop_valid_reg <= pop_ok;
    end
  end

`ifdef FIFO_CTRL_ERR_EN
  logic overflow_reg, underflow_reg;

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

  // A new error in the same cycle as clr_err must not be lost, so set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (push && full && !pop) overflow_reg <= 1'b1;
      else if (clr_err)         overflow_reg <= 1'b0;
      if (pop && empty)         underflow_reg <= 1'b1;
      else if (clr_err)         underflow_reg <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed testbench for fifo_ctrl (DEPTH 8) with a behavioural read-old-data RAM alongside.
module tb_fifo_ctrl;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [7:0]    data_in = 8'h00;
  logic [7:0]    data_out;
  logic          wr_en, rd_en, full, empty, pop_valid;
  logic [AW-1:0] count_push, count_pop;
  logic [AW:0]   usedw;
`ifdef FIFO_CTRL_ERR_EN
  logic          clr_err = 1'b0;
  logic          overflow, underflow;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [DEPTH];

  always #5 clk = ~clk;

  fifo_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
`ifdef FIFO_CTRL_ERR_EN
    .clr_err    (clr_err),
    .overflow   (overflow),
    .underflow  (underflow),
`endif
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .count_push (count_push),
    .count_pop  (count_pop),
    .full       (full),
    .empty      (empty),
    .usedw      (usedw),
    .pop_valid  (pop_valid)
  );

  // RAM stand-in: registered read returns the old word when addresses collide.
  always @(posedge clk) begin
    if (wr_en) mem[count_push] <= data_in;
    if (rd_en) data_out <= mem[count_pop];
  end

  task automatic drive(input logic p, input logic q, input logic [7:0] d);
    @(negedge clk);
    push = p; pop = q; data_in = d;
    #1;
    $display("txn t=%0t push=%0b pop=%0b data=%02h wr_en=%0b rd_en=%0b usedw=%0d", $time, p, q, d, wr_en, rd_en, usedw);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; push = 1'b0; pop = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; push = 1'b1; pop = 1'b1;
    tick();
    tick();
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got %0b expected 0", wr_en); end
    checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en: got %0b expected 0", rd_en); end
    checks++; if (count_push !== 3'd0) begin failures++; $display("FAIL reset_count_push: got %0d expected 0", count_push); end
    checks++; if (count_pop !== 3'd0) begin failures++; $display("FAIL reset_count_pop: got %0d expected 0", count_pop); end
    checks++; if (usedw !== 4'd0) begin failures++; $display("FAIL reset_usedw: got %0d expected 0", usedw); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_flags: got empty=%0b full=%0b expected 1/0", empty, full); end
    checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL reset_pop_valid: got %0b expected 0", pop_valid); end
`ifdef FIFO_CTRL_ERR_EN
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL reset_err: got %0b/%0b expected 0/0", overflow, underflow); end
`endif
    @(negedge clk);
    push = 1'b0; pop = 1'b0; rst = 1'b0;
  endtask

  task automatic test_push5();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 8'(i + 1));
      checks++; if (wr_en !== 1'b1 || count_push !== 3'(i)) begin failures++; $display("FAIL push5_wr: got wr_en=%0b addr=%0d expected 1/%0d", wr_en, count_push, i); end
      tick();
      checks++; if (usedw !== 4'(i + 1)) begin failures++; $display("FAIL push5_usedw: got %0d expected %0d", usedw, i + 1); end
    end
    drive(1'b0, 1'b0, 8'h00);
    checks++; if (count_push !== 3'd5 || count_pop !== 3'd0) begin failures++; $display("FAIL push5_ptrs: got %0d/%0d expected 5/0", count_push, count_pop); end
    checks++; if (empty !== 1'b0 || full !== 1'b0) begin failures++; $display("FAIL push5_flags: got empty=%0b full=%0b expected 0/0", empty, full); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 8'(8'h10 + i));
      tick();
      if (i == DEPTH - 2) begin
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL full_early: got %0b expected 0 at usedw 7", full); end
      end
    end
    checks++; if (full !== 1'b1 || usedw !== 4'd8) begin failures++; $display("FAIL full_set: got full=%0b usedw=%0d expected 1/8", full, usedw); end
    drive(1'b1, 1'b0, 8'h99);
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL full_refuse_wr_en: got %0b expected 0", wr_en); end
    tick();
    checks++; if (usedw !== 4'd8 || count_push !== 3'd0 || full !== 1'b1) begin failures++; $display("FAIL full_refuse_state: got usedw=%0d wp=%0d full=%0b expected 8/0/1", usedw, count_push, full); end
`ifdef FIFO_CTRL_ERR_EN
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL overflow: got %0b expected 1", overflow); end
`endif
  endtask

  // Continues from a full FIFO holding 0x10..0x17 with both pointers at 0.
  task automatic test_full_simul();
    logic [7:0] exp_d;
    drive(1'b1, 1'b1, 8'hEE);
    checks++; if (wr_en !== 1'b1 || rd_en !== 1'b1 || count_pop !== 3'd0) begin failures++; $display("FAIL fullsim_en: got wr=%0b rd=%0b rp=%0d expected 1/1/0", wr_en, rd_en, count_pop); end
    tick();
    checks++; if (usedw !== 4'd8 || full !== 1'b1) begin failures++; $display("FAIL fullsim_state: got usedw=%0d full=%0b expected 8/1", usedw, full); end
    checks++; if (pop_valid !== 1'b1 || data_out !== 8'h10) begin failures++; $display("FAIL fullsim_data: got pv=%0b data=%02h expected 1/10", pop_valid, data_out); end
    for (int i = 0; i < DEPTH; i++) begin
      exp_d = (i < DEPTH - 1) ? 8'(8'h11 + i) : 8'hEE;
      drive(1'b0, 1'b1, 8'h00);
      tick();
      checks++; if (pop_valid !== 1'b1 || data_out !== exp_d) begin failures++; $display("FAIL drain_data: got pv=%0b data=%02h expected 1/%02h", pop_valid, data_out, exp_d); end
    end
    checks++; if (empty !== 1'b1 || usedw !== 4'd0) begin failures++; $display("FAIL drain_empty: got empty=%0b usedw=%0d expected 1/0", empty, usedw); end
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_push_pop();
    do_reset();
    drive(1'b1, 1'b0, 8'hA5);
    checks++; if (wr_en !== 1'b1 || count_push !== 3'd0) begin failures++; $display("FAIL a5_push: got wr=%0b addr=%0d expected 1/0", wr_en, count_push); end
    tick();
    checks++; if (empty !== 1'b0 || usedw !== 4'd1) begin failures++; $display("FAIL a5_after_push: got empty=%0b usedw=%0d expected 0/1", empty, usedw); end
    drive(1'b0, 1'b1, 8'h00);
    checks++; if (rd_en !== 1'b1 || count_pop !== 3'd0) begin failures++; $display("FAIL a5_pop: got rd=%0b addr=%0d expected 1/0", rd_en, count_pop); end
    tick();
    checks++; if (pop_valid !== 1'b1 || data_out !== 8'hA5) begin failures++; $display("FAIL a5_data: got pv=%0b data=%02h expected 1/a5", pop_valid, data_out); end
    checks++; if (empty !== 1'b1 || usedw !== 4'd0) begin failures++; $display("FAIL a5_empty: got empty=%0b usedw=%0d expected 1/0", empty, usedw); end
    drive(1'b0, 1'b0, 8'h00);
    tick();
    checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL a5_pv_drop: got %0b expected 0", pop_valid); end
  endtask

  task automatic test_empty_simul();
    do_reset();
    drive(1'b1, 1'b1, 8'h3C);
    checks++; if (wr_en !== 1'b1 || rd_en !== 1'b0) begin failures++; $display("FAIL emptysim_en: got wr=%0b rd=%0b expected 1/0", wr_en, rd_en); end
    tick();
    checks++; if (pop_valid !== 1'b0 || usedw !== 4'd1 || count_pop !== 3'd0) begin failures++; $display("FAIL emptysim_state: got pv=%0b usedw=%0d rp=%0d expected 0/1/0", pop_valid, usedw, count_pop); end
`ifdef FIFO_CTRL_ERR_EN
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL underflow: got %0b expected 1", underflow); end
    clr_err = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    tick();
    clr_err = 1'b0;
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL clr_err: got %0b expected 0", underflow); end
`endif
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_rp;
    do_reset();
    drive(1'b1, 1'b0, 8'h80);
    tick();
    exp_rp = 3'd0;
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b1, 8'(8'h81 + k));
      checks++; if (rd_en !== 1'b1 || count_pop !== exp_rp || count_push !== 3'(exp_rp + 3'd1)) begin failures++; $display("FAIL b2b_ptrs: got rd=%0b rp=%0d wp=%0d expected 1/%0d/%0d", rd_en, count_pop, count_push, exp_rp, 3'(exp_rp + 3'd1)); end
      tick();
      checks++; if (pop_valid !== 1'b1 || data_out !== 8'(8'h80 + k) || usedw !== 4'd1) begin failures++; $display("FAIL b2b_data: got pv=%0b data=%02h usedw=%0d expected 1/%02h/1", pop_valid, data_out, usedw, 8'(8'h80 + k)); end
      exp_rp = exp_rp + 3'd1;
    end
    // Reset lands between edges with requests still asserted.
    #2;
    rst = 1'b1;
    #1;
    checks++; if (count_push !== 3'd0 || count_pop !== 3'd0 || usedw !== 4'd0) begin failures++; $display("FAIL async_rst_regs: got wp=%0d rp=%0d usedw=%0d expected 0/0/0", count_push, count_pop, usedw); end
    checks++; if (empty !== 1'b1 || full !== 1'b0 || pop_valid !== 1'b0) begin failures++; $display("FAIL async_rst_flags: got empty=%0b full=%0b pv=%0b expected 1/0/0", empty, full, pop_valid); end
    checks++; if (wr_en !== 1'b0 || rd_en !== 1'b0) begin failures++; $display("FAIL async_rst_en: got wr=%0b rd=%0b expected 0/0", wr_en, rd_en); end
    @(negedge clk);
    push = 1'b0; pop = 1'b0; rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_push5();
    test_full();
    test_full_simul();
    test_push_pop();
    test_empty_simul();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Sequencing controller for the dual-port `ram_vector` FIFO storage: accepts push/pop requests from the producer/consumer side and drives the RAM's `wr_en`, `rd_en`, `count_push` and `count_pop`. Tracks occupancy with a three-state FSM and publishes `full`, `empty` and `usedw`. Flags the cycle on which RAM read data is valid. Sits between the processor-side FIFO wrapper and the RAM.

## Interface
- `DEPTH`, default `VECTOR_SIZE` (from `fifo_pkg`), number of RAM entries; power of two, at least 2.
- `AW`, default `$clog2(DEPTH)`, pointer width; matches `address_t`.
- `clk` input 1: single clock, rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `push` input 1: producer write request; data is presented directly to the RAM `data_in` in the same cycle.
- `pop` input 1: consumer read request.
- `wr_en` output 1: RAM write enable for the accepted push.
- `rd_en` output 1: RAM read enable for the accepted pop.
- `count_push` output AW: RAM write address (write pointer).
- `count_pop` output AW: RAM read address (read pointer).
- `full` output 1: occupancy == DEPTH.
- `empty` output 1: occupancy == 0.
- `usedw` output AW+1: occupancy, 0..DEPTH.
- `pop_valid` output 1: RAM `data_out` holds the popped word this cycle.
- `overflow`, `underflow` output 1 each: sticky error flags; present only with `FIFO_CTRL_ERR_EN`.
- `clr_err` input 1: clears the sticky flags; present only with `FIFO_CTRL_ERR_EN`.

## Operation
- FSM states: EMPTY, PARTIAL, FULL; the state is registered.
- Transitions:
  - EMPTY→PARTIAL on an accepted push (DEPTH ≥ 2).
  - PARTIAL→FULL when push-only and usedw == DEPTH-1.
  - PARTIAL→EMPTY when pop-only and usedw == 1.
  - FULL→PARTIAL on pop-only.
  - Push+pop together leaves the state unchanged.
- `empty` = (state == EMPTY); `full` = (state == FULL); both are registered decodes and carry no combinational path from `push` or `pop`.
- Accept rules:
  - `push_ok` = push & (!full | pop).
  - `pop_ok` = pop & !empty.
  - A push on a full FIFO is accepted only when paired with a pop; the RAM's read-old-data semantics make the shared address safe.
  - A pop on an empty FIFO is refused even when paired with a push; the push alone is accepted.
- `wr_en` = push_ok and `rd_en` = pop_ok, both combinational. `count_push` and `count_pop` are the current pointer registers.
- Pointers increment by 1 on accept and wrap from DEPTH-1 to 0 (natural AW-bit rollover).
- `usedw` changes by +1 (push only), -1 (pop only) or 0 (both, or neither).
- `pop_valid` is registered: it equals the previous cycle's pop_ok.
- Refused requests leave the pointers, `usedw` and the state unchanged, and produce no RAM enable.

## Timing
- Reset values: state EMPTY, `count_push` 0, `count_pop` 0, `usedw` 0, `empty` 1, `full` 0, `pop_valid` 0, `overflow` 0, `underflow` 0. `wr_en` and `rd_en` are 0 because requests are masked while `rst` is high.
- Push latency: the word is written on the accepting edge. `empty` deasserts and `usedw` updates one cycle after the accept.
- Pop latency: the RAM registers data on the accepting edge. `data_out` and `pop_valid` are valid in the following cycle, for one cycle.
- Back-to-back pops every cycle sustain one word per cycle; `pop_valid` stays high continuously.
- Reset asserted mid-operation: all state clears immediately. The RAM contents are not cleared and are irrelevant afterwards. An in-flight `pop_valid` is dropped.

## Configuration
- `FIFO_CTRL_ERR_EN` defined:
  - `overflow` sets on push & full & !pop.
  - `underflow` sets on pop & empty.
  - Both flags hold until `clr_err` or `rst`.
  - If a set condition and `clr_err` occur in the same cycle, set wins.
- `FIFO_CTRL_ERR_EN` undefined: the `overflow`, `underflow` and `clr_err` ports and their logic are absent. Refused requests are silently ignored.

## Test plan
- Reset, then push 5 words (DEPTH 8) -> `count_push` reaches 5, `usedw` reaches 5, `empty` 0, `full` 0, `count_pop` stays 0.
- Fill 8 words, then push again -> `full` 1, no `wr_en`, `usedw` stays 8, `overflow` 1 (with ERR_EN).
- Push 0xA5, pop next cycle -> `rd_en` 1 at address 0; next cycle `pop_valid` 1 and `data_out` 0xA5; `empty` returns to 1.
- Push+pop simultaneously while full -> both accepted, `usedw` stays 8, popped word is the old entry, `full` stays 1.
- Push+pop simultaneously while empty -> only the push is accepted, `pop_valid` stays 0, `usedw` becomes 1, `underflow` 1 (with ERR_EN).
- Run 20 push/pop pairs to wrap the pointers, then assert `rst` mid-stream -> pointers wrap 7→0 with data order preserved; on `rst` all outputs return to their reset values asynchronously.
